// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: NEC infrared protocol decoder.
//   Measures mark/space durations on the synchronized IR input. It then
//   decodes the leader, 32 data bits and the stop mark, or a repeat frame.
// Ports:
//   clk           - sole clock, rising edge
//   reset         - asynchronous, active-high
//   ir_in         - raw demodulated IR pin (active-low mark, idle high, async)
//   ir_command    - last accepted 32-bit frame, first received bit in bit 0
//   ir_data_ready - 1-cycle pulse when ir_command updates
//   ir_repeat     - 1-cycle pulse on a valid repeat frame
//   ir_error      - 1-cycle pulse when a frame aborts after its leader mark
//   busy          - high whenever the decoder is not idle
// Optional feature: define IR_CMD_CHECK_EN to accept a frame only when
//   bits[31:24] == ~bits[23:16]. A failed check pulses ir_error instead.
module ir_nec_receiver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_US = 11000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_in,
  output logic [31:0] ir_command,
  output logic        ir_data_ready,
  output logic        ir_repeat,
  output logic        ir_error,
  output logic        busy
);
  localparam int CYC_US  = CLK_FREQ / 1_000_000;
  localparam int CNT_MAX = TIMEOUT_US * CYC_US;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_DATA_MARK, S_DATA_SPACE, S_REPEAT_MARK
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_bits;
  logic [31:0]   r_shift;

  logic          w_fall, w_rise, w_edge, w_sat;
  logic [CW:0]   w_dur;
  logic          w_dr, w_rep, w_err, w_shift, w_bit, w_clr_bits;

  // The counter is cleared in the cycle after an edge is seen. The level
  // length is therefore the count plus the edge cycle itself.
  function automatic logic in_win(input logic [CW:0] dur, input int lo_us, input int hi_us);
    return (int'(dur) >= lo_us * CYC_US) && (int'(dur) <= hi_us * CYC_US);
  endfunction

  assign w_fall = r_prev & ~r_sync[1];
  assign w_rise = ~r_prev & r_sync[1];
  assign w_edge = w_fall | w_rise;
  assign w_sat  = (r_cnt == CNT_SAT);
  assign w_dur  = {1'b0, r_cnt} + 1'b1;
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], ir_in};
      r_prev <= r_sync[1];
      if (w_edge)      r_cnt <= '0;
      else if (!w_sat) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bits        <= '0;
      r_shift       <= '0;
      ir_command    <= '0;
      ir_data_ready <= 1'b0;
      ir_repeat     <= 1'b0;
      ir_error      <= 1'b0;
    end else begin
      r_state       <= w_next;
      ir_data_ready <= w_dr;
      ir_repeat     <= w_rep;
      ir_error      <= w_err;
      if (w_clr_bits)   r_bits <= '0;
      else if (w_shift) r_bits <= r_bits + 1'b1;
      if (w_shift) r_shift <= {w_bit, r_shift[31:1]};
      if (w_dr)    ir_command <= r_shift;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_dr       = 1'b0;
    w_rep      = 1'b0;
    w_err      = 1'b0;
    w_shift    = 1'b0;
    w_bit      = 1'b0;
    w_clr_bits = 1'b0;
    case (r_state)
      S_IDLE: if (w_fall) w_next = S_LEAD_MARK;
      S_LEAD_MARK: begin
        // A bad or over-long leader mark is treated as noise, so no error.
        if (w_rise) w_next = in_win(w_dur, 8000, 10000) ? S_LEAD_SPACE : S_IDLE;
        else if (w_sat) w_next = S_IDLE;
      end
      S_LEAD_SPACE: begin
        if (w_fall) begin
          if (in_win(w_dur, 4000, 5000)) begin
            w_next     = S_DATA_MARK;
            w_clr_bits = 1'b1;
          end else if (in_win(w_dur, 2000, 2500)) begin
            w_next = S_REPEAT_MARK;
          end else begin
            w_next = S_IDLE;
            w_err  = 1'b1;
          end
        end else if (w_sat) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end
      end
      S_DATA_MARK: begin
        if (w_rise) begin
          w_next = S_IDLE;
          if (!in_win(w_dur, 400, 700)) w_err = 1'b1;
          else if (r_bits < 6'd32)      w_next = S_DATA_SPACE;
          else begin
            // The 32nd bit is already shifted in, so this mark is the stop mark.
`ifdef IR_CMD_CHECK_EN
            if (r_shift[31:24] == ~r_shift[23:16]) w_dr = 1'b1;
            else                                   w_err = 1'b1;
`else
            w_dr = 1'b1;
`endif
          end
        end else if (w_sat) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end
      end
      S_DATA_SPACE: begin
        if (w_fall) begin
          w_next = S_DATA_MARK;
          if (in_win(w_dur, 400, 700)) begin
            w_shift = 1'b1;
          end else if (in_win(w_dur, 1400, 1900)) begin
            w_shift = 1'b1;
            w_bit   = 1'b1;
          end else begin
            w_next = S_IDLE;
            w_err  = 1'b1;
          end
        end else if (w_sat) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end
      end
      S_REPEAT_MARK: begin
        if (w_rise) begin
          w_next = S_IDLE;
          if (in_win(w_dur, 400, 700)) w_rep = 1'b1;
          else                         w_err = 1'b1;
        end else if (w_sat) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ir_nec_receiver.sv
// tb_ir_nec_receiver: self-checking bench for ir_nec_receiver at 1 clk = 1 us.
//   Each frame is a list of alternating mark/space lengths in microseconds.
//   A protocol-level model computes the expected result for that list.
//   The bench then plays the list into the DUT and compares the pulses.
module tb_ir_nec_receiver;
  localparam int K_NONE = 0, K_DATA = 1, K_REP = 2, K_ERR = 3;

  logic        clk = 1'b0, reset = 1'b1, ir_in = 1'b1;
  logic [31:0] ir_command;
  logic        ir_data_ready, ir_repeat, ir_error, busy;

  int cyc = 0, n_vec = 0, n_miss = 0;
  int n_dr = 0, n_rep = 0, n_err = 0, dr_cyc = 0, err_cyc = 0, excl_bad = 0;
  int seg_cyc = 0, rise_cyc = 0;
  int frm[$];
  logic [31:0] exp_cmd = '0;

  ir_nec_receiver #(.CLK_FREQ(1_000_000), .TIMEOUT_US(11000)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .ir_command(ir_command),
    .ir_data_ready(ir_data_ready), .ir_repeat(ir_repeat), .ir_error(ir_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (ir_data_ready) begin n_dr <= n_dr + 1; dr_cyc <= cyc; end
      if (ir_repeat) n_rep <= n_rep + 1;
      if (ir_error) begin n_err <= n_err + 1; err_cyc <= cyc; end
      if (int'(ir_data_ready) + int'(ir_repeat) + int'(ir_error) > 1) excl_bad <= excl_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_w(input int d, input int lo, input int hi);
    return d >= lo && d <= hi;
  endfunction

  // Protocol reference: walk the level list and decide what the frame means.
  // A missing level means the line idles high and then times out.
  function automatic void nec_model(input int q[$], output int kind, output logic [31:0] v);
    v    = '0;
    kind = K_NONE;
    if (q.size() < 1 || !in_w(q[0], 8000, 10000)) return;
    kind = K_ERR;
    if (q.size() < 2) return;
    if (in_w(q[1], 2000, 2500)) begin
      if (q.size() > 2 && in_w(q[2], 400, 700)) kind = K_REP;
      return;
    end
    if (!in_w(q[1], 4000, 5000)) return;
    for (int i = 0; i <= 32; i++) begin
      if (2 + 2*i >= q.size() || !in_w(q[2 + 2*i], 400, 700)) return;
      if (i < 32) begin
        if (3 + 2*i >= q.size()) return;
        if (in_w(q[3 + 2*i], 1400, 1900))   v[i] = 1'b1;
        else if (!in_w(q[3 + 2*i], 400, 700)) return;
      end
    end
`ifdef IR_CMD_CHECK_EN
    if (v[31:24] != ~v[23:16]) return;
`endif
    kind = K_DATA;
  endfunction

  function automatic int good_len(input int lo, input int hi);
    case ($urandom_range(3))
      0:       return lo;
      1:       return hi;
      default: return int'($urandom_range(hi, lo));
    endcase
  endfunction

  // Build a frame carrying v. Each mark or space has a bad_pct% chance of
  // falling just outside its window.
  task automatic build(input logic [31:0] v, input int bad_pct);
    frm.delete();
    frm.push_back(int'($urandom_range(10000, 8000)));
    frm.push_back(int'($urandom_range(5000, 4000)));
    for (int i = 0; i <= 32; i++) begin
      if (int'($urandom_range(99)) < bad_pct) frm.push_back($urandom_range(1) ? 399 : 701);
      else                                    frm.push_back(good_len(400, 700));
      if (i < 32) begin
        if (int'($urandom_range(99)) < bad_pct) frm.push_back(int'($urandom_range(1399, 701)));
        else if (v[i])                          frm.push_back(good_len(1400, 1900));
        else                                    frm.push_back(good_len(400, 700));
      end
    end
  endtask

  task automatic play();
    for (int i = 0; i < frm.size(); i++) begin
      ir_in   = (i % 2 == 0) ? 1'b0 : 1'b1;
      seg_cyc = cyc;
      repeat (frm[i]) @(posedge clk);
      #1;
    end
    ir_in    = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic run_case(input string tag, input int idle);
    int kind, d0, r0, e0;
    logic [31:0] v;
    nec_model(frm, kind, v);
    d0 = n_dr; r0 = n_rep; e0 = n_err;
    play();
    repeat (idle) @(posedge clk);
    #1;
    if (kind == K_DATA) exp_cmd = v;
    chk({tag, ".ready"}, 32'(n_dr - d0),  32'(kind == K_DATA));
    chk({tag, ".rep"},   32'(n_rep - r0), 32'(kind == K_REP));
    chk({tag, ".err"},   32'(n_err - e0), 32'(kind == K_ERR));
    chk({tag, ".cmd"},   ir_command, exp_cmd);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    if (kind == K_DATA) chk({tag, ".lat"}, 32'(dr_cyc - rise_cyc), 32'd3);
  endtask

  initial begin
    int f, e0;
    logic [31:0] v;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.cmd",   ir_command, 32'd0);
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.pulse", {29'd0, ir_data_ready, ir_repeat, ir_error}, 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    frm = {7000};
    run_case("lead7k", 200);
    build(32'hED126B86, 0);
    run_case("frmED", 200);
    frm = {9000, 2250, 560};
    run_case("repeat", 200);
    build(32'hEC126B86, 0);
    run_case("frmEC", 200);

    // Line stuck low after bit 10: abort must come from the timeout.
    build(32'h5AA5C33C, 0);
    while (frm.size() > 24) void'(frm.pop_back());
    frm.push_back(15000);
    run_case("tmo", 200);
    f = seg_cyc;
    chk("tmo.when", 32'(in_w(err_cyc - f, 11000, 11006)), 32'd1);
    build(32'hB54A02FD, 0);
    run_case("post_tmo", 200);

    // Reset in the middle of bit 21.
    build(32'h12345678, 0);
    while (frm.size() > 44) void'(frm.pop_back());
    frm.push_back(560);
    play();
    e0 = n_err;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.cmd",   ir_command, 32'd0);
    chk("mid.busy",  32'(busy), 32'd0);
    chk("mid.pulse", {29'd0, ir_data_ready, ir_repeat, ir_error}, 32'd0);
    reset   = 1'b0;
    exp_cmd = '0;
    repeat (200) @(posedge clk);
    #1;
    chk("mid.noerr", 32'(n_err - e0), 32'd0);
    build(32'hFE016B86, 0);
    run_case("post_rst", 200);

    for (int n = 0; n < 4; n++) begin
      v = $urandom;
      case ($urandom_range(2))
        0: build(v, 1);
        1: frm = {int'($urandom_range(10000, 8000)), int'($urandom_range(2500, 2000)),
                  int'($urandom_range(750, 350))};
        default: begin
          build(v, 0);
          frm[1] = int'($urandom_range(5200, 1800));
        end
      endcase
      run_case($sformatf("rnd%0d", n), 200);
    end

    chk("exclusive", 32'(excl_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
